// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the pipelined ALU: opcode encodings,
//               NZCV bit positions and opcode classification helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND = 5'b00000,
    OP_EOR = 5'b00001,
    OP_SUB = 5'b00010,
    OP_RSB = 5'b00011,
    OP_ADD = 5'b00100,
    OP_ADC = 5'b00101,
    OP_SBC = 5'b00110,
    OP_RSC = 5'b00111,
    OP_TST = 5'b01000,
    OP_TEQ = 5'b01001,
    OP_CMP = 5'b01010,
    OP_CMN = 5'b01011,
    OP_ORR = 5'b01100,
    OP_MOV = 5'b01101,
    OP_BIC = 5'b01110,
    OP_MVN = 5'b01111,
    OP_MUL = 5'b10000
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare-class ops: never write back, always commit flags.
  function automatic logic is_test_op(input logic [4:0] cmd);
    return (cmd == OP_TST) || (cmd == OP_TEQ) || (cmd == OP_CMP) || (cmd == OP_CMN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Radix-2 shift-add multiplier, one partial product per cycle.
//               Returns the low WIDTH bits of a*b (unsigned).
// Ports       : clk, rst_n     - clock / async active-low reset
//               start          - load operands and begin
//               abort          - synchronous cancel of the running multiply
//               a, b           - operands, sampled on start
//               done           - high for the cycle product is final
//               product        - accumulated result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(ITERS + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CW'(ITERS);
      run    <= 1'b1;
    end else if (run) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        // Result consumed by the parent on this edge.
        run <= 1'b0;
      end
    end
  end

  assign done    = run && (cnt == '0);
  assign product = acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Handshaked ARM-style data-processing ALU with iterative
//               multiply, owning the NZCV flag register and a one-entry
//               registered output stage.
// Ports       : CLOCK_50, RESET_n   - clock / async active-low reset
//               flush               - abort in-flight op and output entry
//               in_valid/in_ready   - request handshake
//               src1, src2, CTRL_cmd, set_flags,
//               src2shift_carry, was_shifted - request payload
//               out_valid/out_ready - result handshake
//               ALU_output, out_wb, out_illegal - result entry
//               NZCV                - architectural flags (N = bit 3)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             CLOCK_50,
  input  logic             RESET_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             src2shift_carry,
  input  logic             was_shifted,
  input  logic [4:0]       CTRL_cmd,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_output,
  output logic             out_wb,
  output logic             out_illegal,
  output logic [3:0]       NZCV
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e           state, state_nx;
  logic             rdy_en;      // holds in_ready low until the first edge after reset
  logic             accept, pop, is_mul, mul_start, mul_done, mul_sf;
  logic [WIDTH-1:0] product;

  logic [WIDTH-1:0] add_a, add_b, result;
  logic             add_cin, is_arith, illegal, wr_back, commit;
  logic [WIDTH:0]   sum;
  logic [3:0]       flags_nx, mul_flags;

  // A request coinciding with flush must not be accepted.
  assign in_ready  = rdy_en && (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign is_mul    = (CTRL_cmd == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .ITERS (MUL_CYCLES)
  ) u_mul (
    .clk     (CLOCK_50),
    .rst_n   (RESET_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (src1),
    .b       (src2),
    .done    (mul_done),
    .product (product)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (mul_start) state_nx = ST_MUL;
        ST_MUL:  if (mul_done)  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // ---------------- adder operand selection ----------------
  // Subtraction is a + ~b + cin; reverse forms swap the operands.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (CTRL_cmd)
      OP_SUB, OP_CMP: begin add_a = src1; add_b = ~src2; add_cin = 1'b1;         end
      OP_RSB:         begin add_a = src2; add_b = ~src1; add_cin = 1'b1;         end
      OP_ADD, OP_CMN: begin add_a = src1; add_b = src2;  add_cin = 1'b0;         end
      OP_ADC:         begin add_a = src1; add_b = src2;  add_cin = NZCV[FLAG_C]; end
      OP_SBC:         begin add_a = src1; add_b = ~src2; add_cin = NZCV[FLAG_C]; end
      OP_RSC:         begin add_a = src2; add_b = ~src1; add_cin = NZCV[FLAG_C]; end
      default:        is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // ---------------- result and flag computation ----------------
  always_comb begin
    result   = '0;
    illegal  = 1'b0;
    flags_nx = NZCV;
    case (CTRL_cmd)
      OP_AND, OP_TST: result = src1 & src2;
      OP_EOR, OP_TEQ: result = src1 ^ src2;
      OP_ORR:         result = src1 | src2;
      OP_MOV:         result = src2;
      OP_BIC:         result = src1 & ~src2;
      OP_MVN:         result = ~src2;
      OP_MUL:         result = '0;   // product is loaded from the multiplier later
      default: begin
        if (is_arith) result = sum[WIDTH-1:0];
        else          illegal = 1'b1;
      end
    endcase

    if (is_arith) begin
      flags_nx[FLAG_N] = result[WIDTH-1];
      flags_nx[FLAG_Z] = (result == '0);
      flags_nx[FLAG_C] = sum[WIDTH];
      // Overflow: both addends share a sign that the result does not.
      flags_nx[FLAG_V] = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                         (result[WIDTH-1] != add_a[WIDTH-1]);
    end else if (!illegal && !is_mul) begin
      flags_nx[FLAG_N] = result[WIDTH-1];
      flags_nx[FLAG_Z] = (result == '0);
      if (was_shifted) flags_nx[FLAG_C] = src2shift_carry;
    end
  end

  assign wr_back = !illegal && !is_test_op(CTRL_cmd);
  assign commit  = !illegal && (set_flags || is_test_op(CTRL_cmd));

  always_comb begin
    mul_flags         = NZCV;
    mul_flags[FLAG_N] = product[WIDTH-1];
    mul_flags[FLAG_Z] = (product == '0);
  end

  // ---------------- output entry and flag register ----------------
  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      rdy_en      <= 1'b0;
      mul_sf      <= 1'b0;
      out_valid   <= 1'b0;
      ALU_output  <= '0;
      out_wb      <= 1'b0;
      out_illegal <= 1'b0;
      NZCV        <= 4'b0000;
    end else begin
      rdy_en <= 1'b1;
      if (mul_start) mul_sf <= set_flags;

      if (flush) begin
        out_valid <= 1'b0;
      end else if (state == ST_MUL) begin
        if (mul_done) begin
          out_valid   <= 1'b1;
          ALU_output  <= product;
          out_wb      <= 1'b1;
          out_illegal <= 1'b0;
          if (mul_sf) NZCV <= mul_flags;
        end
      end else if (accept && !is_mul) begin
        out_valid   <= 1'b1;
        ALU_output  <= result;
        out_wb      <= wr_back;
        out_illegal <= illegal;
        if (commit) NZCV <= flags_nx;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH = 32): directed
//               vector table, multi-cycle corner sequences and a randomized
//               run scored against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        RESET_n, flush, in_valid, in_ready;
  logic [31:0] src1, src2, ALU_output;
  logic        src2shift_carry, was_shifted, set_flags;
  logic [4:0]  CTRL_cmd;
  logic        out_valid, out_ready, out_wb, out_illegal;
  logic [3:0]  NZCV;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .CLOCK_50        (clk),
    .RESET_n         (RESET_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .src1            (src1),
    .src2            (src2),
    .src2shift_carry (src2shift_carry),
    .was_shifted     (was_shifted),
    .CTRL_cmd        (CTRL_cmd),
    .set_flags       (set_flags),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .ALU_output      (ALU_output),
    .out_wb          (out_wb),
    .out_illegal     (out_illegal),
    .NZCV            (NZCV)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        wb;
    logic        ill;
    logic [3:0]  f;
  } exp_t;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [31:0] a, b;
    logic        sc, ws, sf;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain signed/unsigned 64-bit arithmetic.
  function automatic exp_t ref_op(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic sc, input logic ws, input logic sf, input logic [3:0] f);
    exp_t        e;
    logic [31:0] x, y, r;
    longint      ut, st, lim_hi, lim_lo;
    logic        k, sub, arith, c, v, test;
    logic [3:0]  nf;
    lim_hi = 2147483647;
    lim_lo = -lim_hi - 1;
    arith = 1'b0; sub = 1'b0; x = a; y = b; k = 1'b0; r = '0;
    c = 1'b0; v = 1'b0; ut = 0; st = 0; nf = f;
    e.wb = 1'b1; e.ill = 1'b0;
    test = (cmd >= 5'd8) && (cmd <= 5'd11);
    case (cmd)
      5'd0, 5'd8:  r = a & b;
      5'd1, 5'd9:  r = a ^ b;
      5'd12:       r = a | b;
      5'd13:       r = b;
      5'd14:       r = a & ~b;
      5'd15:       r = ~b;
      5'd16:       r = a * b;
      5'd2, 5'd10: begin arith = 1'b1; sub = 1'b1; end
      5'd3:        begin arith = 1'b1; sub = 1'b1; x = b; y = a; end
      5'd4, 5'd11: arith = 1'b1;
      5'd5:        begin arith = 1'b1; k = f[1]; end
      5'd6:        begin arith = 1'b1; sub = 1'b1; k = !f[1]; end
      5'd7:        begin arith = 1'b1; sub = 1'b1; x = b; y = a; k = !f[1]; end
      default:     begin e.ill = 1'b1; e.wb = 1'b0; end
    endcase
    if (arith) begin
      if (sub) begin
        ut = longint'(x) - longint'(y) - longint'(k);
        st = longint'($signed(x)) - longint'($signed(y)) - longint'(k);
        c  = (ut >= 0);
      end else begin
        ut = longint'(x) + longint'(y) + longint'(k);
        st = longint'($signed(x)) + longint'($signed(y)) + longint'(k);
        c  = ((ut >> 32) != 0);
      end
      r  = ut[31:0];
      v  = (st > lim_hi) || (st < lim_lo);
      nf = {r[31], (r == 32'd0), c, v};
    end else if (!e.ill) begin
      nf[3] = r[31];
      nf[2] = (r == 32'd0);
      if (ws && cmd != 5'd16) nf[1] = sc;
    end
    if (test) e.wb = 1'b0;
    e.res = e.ill ? 32'd0 : r;
    e.f   = (!e.ill && (sf || test)) ? nf : f;
    return e;
  endfunction

  function automatic vec_t mk(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              input logic sc, input logic ws, input logic sf,
                              input logic [31:0] res, input logic wb, input logic ill, input logic [3:0] f);
    vec_t v;
    v.cmd = cmd; v.a = a; v.b = b; v.sc = sc; v.ws = ws; v.sf = sf;
    v.e.res = res; v.e.wb = wb; v.e.ill = ill; v.e.f = f;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic ws, input logic sf);
    CTRL_cmd = cmd; src1 = a; src2 = b;
    src2shift_carry = sc; was_shifted = ws; set_flags = sf;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input logic [4:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic ws, input logic sf);
    int guard;
    guard = 0;
    drive(cmd, a, b, sc, ws, sf);
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 for cmd %0h", cmd);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  exp_t q[$];

  // Called at negedge when a pop is observed.
  task automatic check_pop();
    exp_t e, act;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL rand_pop_empty: got out_valid 1 expected no pending result");
    end else begin
      e = q.pop_front();
      act = {ALU_output, out_wb, out_illegal, NZCV};
      if (!e.wb && !e.ill) begin act.res = '0; e.res = '0; end
      if (act !== e) begin
        n_fail++;
        $display("FAIL rand_result: got res=%0h wb=%0b ill=%0b nzcv=%b expected res=%0h wb=%0b ill=%0b nzcv=%b",
                 act.res, act.wb, act.ill, act.f, e.res, e.wb, e.ill, e.f);
      end
    end
  endtask

  vec_t vt[20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic bad;
    logic [3:0] m_f;
    logic acc, pp;

    vt[0]  = mk(5'b00100, 32'd5,         32'hFFFF_FFFA, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 4'b1000); // ADDS
    vt[1]  = mk(5'b00010, 32'd5,         32'hFFFF_FFFA, 0, 0, 1, 32'h0000_000B, 1, 0, 4'b0000); // SUBS
    vt[2]  = mk(5'b01010, 32'd5,         32'hFFFF_FFFA, 0, 0, 0, 32'h0,         0, 0, 4'b0000); // CMP
    vt[3]  = mk(5'b00100, 32'hFFFF_FFFF, 32'd1,         0, 0, 1, 32'h0,         1, 0, 4'b0110); // ADDS
    vt[4]  = mk(5'b00101, 32'd0,         32'd0,         0, 0, 0, 32'h1,         1, 0, 4'b0110); // ADC
    vt[5]  = mk(5'b01101, 32'd0,         32'h8000_0000, 1, 1, 1, 32'h8000_0000, 1, 0, 4'b1010); // MOVS
    vt[6]  = mk(5'b10101, 32'd3,         32'd4,         0, 0, 1, 32'h0,         0, 1, 4'b1010); // reserved
    vt[7]  = mk(5'b00010, 32'h8000_0000, 32'd1,         0, 0, 1, 32'h7FFF_FFFF, 1, 0, 4'b0011); // SUBS ovf
    vt[8]  = mk(5'b01000, 32'hF0,        32'h0F,        0, 0, 0, 32'h0,         0, 0, 4'b0111); // TST
    vt[9]  = mk(5'b01111, 32'd0,         32'd0,         0, 0, 1, 32'hFFFF_FFFF, 1, 0, 4'b1011); // MVNS
    vt[10] = mk(5'b00110, 32'd10,        32'd3,         0, 0, 1, 32'd7,         1, 0, 4'b0010); // SBCS C=1
    vt[11] = mk(5'b00111, 32'd10,        32'd3,         0, 0, 1, 32'hFFFF_FFF9, 1, 0, 4'b1000); // RSCS C=1
    vt[12] = mk(5'b00110, 32'd10,        32'd3,         0, 0, 1, 32'd6,         1, 0, 4'b0010); // SBCS C=0
    vt[13] = mk(5'b01110, 32'hFF,        32'h0F,        0, 0, 0, 32'hF0,        1, 0, 4'b0010); // BIC
    vt[14] = mk(5'b01001, 32'd5,         32'd5,         0, 1, 0, 32'h0,         0, 0, 4'b0100); // TEQ
    vt[15] = mk(5'b01011, 32'h7FFF_FFFF, 32'd1,         0, 0, 0, 32'h0,         0, 0, 4'b1001); // CMN ovf
    vt[16] = mk(5'b01100, 32'hF0,        32'h0F,        0, 0, 1, 32'hFF,        1, 0, 4'b0001); // ORRS
    vt[17] = mk(5'b00011, 32'd1,         32'd0,         0, 0, 1, 32'hFFFF_FFFF, 1, 0, 4'b1000); // RSBS
    vt[18] = mk(5'b00000, 32'hF0,        32'h0F,        1, 1, 1, 32'h0,         1, 0, 4'b0110); // ANDS
    vt[19] = mk(5'b00001, 32'hFF,        32'h0F,        0, 0, 0, 32'hF0,        1, 0, 4'b0110); // EOR

    // ---------------- reset ----------------
    RESET_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(5'd0, 32'd0, 32'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_output", ALU_output, 0);
    check("rst_out_wb_ill", {out_wb, out_illegal}, 0);
    check("rst_nzcv", NZCV, 0);
    check("rst_in_ready", in_ready, 0);
    RESET_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("rdy_after_edge", in_ready, 1);

    // ---------------- back-to-back vector table ----------------
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].cmd, vt[i].a, vt[i].b, vt[i].sc, vt[i].ws, vt[i].sf);
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      if (vt[i].e.wb || vt[i].e.ill)
        check($sformatf("vec%0d_result", i), ALU_output, vt[i].e.res);
      check($sformatf("vec%0d_wb_ill", i), {out_wb, out_illegal}, {vt[i].e.wb, vt[i].e.ill});
      check($sformatf("vec%0d_nzcv", i), NZCV, vt[i].e.f);
    end
    in_valid = 1'b0;

    // ---------------- MUL 7 x 6 with C and V set ----------------
    issue(5'b01010, 32'h8000_0000, 32'd1, 0, 0, 0);          // CMP -> 0011
    check("pre_mul_nzcv", NZCV, 4'b0011);
    issue(5'b10000, 32'd7, 32'd6, 0, 0, 1);
    n = 0; bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("mul_latency", n, 33);
    check("mul_in_ready_low", bad, 0);
    check("mul_result", ALU_output, 42);
    check("mul_nzcv", NZCV, 4'b0011);
    check("mul_wb", {out_wb, out_illegal}, 2'b10);
    @(posedge clk); #1;                                      // pop MUL entry

    // ---------------- back-pressure, then pop + accept ----------------
    out_ready = 1'b0;
    issue(5'b00100, 32'd1, 32'd2, 0, 0, 0);
    drive(5'b00100, 32'd10, 32'd20, 0, 0, 0);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ALU_output !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("stall_stable", bad, 0);
    check("stall_value", ALU_output, 3);
    out_ready = 1'b1;
    #1;
    check("pop_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pop_accept_result", ALU_output, 30);
    check("pop_accept_valid", out_valid, 1);
    @(posedge clk); #1;

    // ---------------- request during flush is dropped ----------------
    drive(5'b00100, 32'd4, 32'd4, 0, 0, 1);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_no_accept", out_valid, 0);
    check("flush_no_accept_nzcv", NZCV, 4'b0011);

    // ---------------- flush mid-MUL ----------------
    issue(5'b10000, 32'd3, 32'd4, 0, 0, 1);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_in_ready", in_ready, 1);
    bad = 1'b0;
    repeat (40) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_result", bad, 0);
    check("flush_nzcv", NZCV, 4'b0011);

    // ---------------- reset mid-MUL ----------------
    issue(5'b10000, 32'd9, 32'd9, 0, 0, 1);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    RESET_n = 1'b0;
    #1;
    check("amid_rst_outputs", {out_valid, out_wb, out_illegal, in_ready}, 0);
    check("amid_rst_alu_output", ALU_output, 0);
    check("amid_rst_nzcv", NZCV, 0);
    @(posedge clk); #1;
    RESET_n = 1'b1;
    bad = 1'b0;
    repeat (45) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_no_result", bad, 0);
    check("rst_ready_again", in_ready, 1);

    // ---------------- randomized run against the model ----------------
    m_f = 4'b0000;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int p;
      logic [4:0] cmd;
      p = $urandom_range(0, 39);
      if (p < 1)      cmd = 5'd16;
      else if (p < 6) cmd = 5'($urandom_range(17, 31));
      else            cmd = 5'($urandom_range(0, 15));
      drive(cmd, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      if (pp) check_pop();
      if (acc) begin
        exp_t e;
        e = ref_op(CTRL_cmd, src1, src2, src2shift_carry, was_shifted, set_flags, m_f);
        m_f = e.f;
        q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() > 0; i++) begin
      @(negedge clk);
      if (out_valid) check_pop();
      @(posedge clk); #1;
    end
    check("rand_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle ALU: executes the 16 ARM-style data-processing opcodes plus an iterative multiply on WIDTH-bit operands. It owns the architectural NZCV flag register, so ADC/SBC/RSC read and update flags internally. It sits between operand fetch/shifter and write-back, with valid/ready handshakes on both sides and a one-entry registered output stage.

## Interface
- WIDTH, 32: operand/result width, ≥ 8.
- MUL_CYCLES, WIDTH: multiplier iterations. Must equal WIDTH for radix-2; the parameter is reserved for radix-4 later.

- CLOCK_50  in  1: clock, rising edge.
- RESET_n  in  1: reset; one clock; reset is asynchronous and active-low.
- flush  in  1: synchronous abort of the in-flight op and the output entry.
- in_valid  in  1: request present.
- in_ready  out  1: request accepted on the edge where in_valid && in_ready.
- src1, src2  in  WIDTH: operands; src2 is already shifted.
- src2shift_carry  in  1: shifter carry-out.
- was_shifted  in  1: src2shift_carry is meaningful.
- CTRL_cmd  in  5: opcode.
- set_flags  in  1: commit flags for this op (S bit).
- out_valid  out  1: result entry valid.
- out_ready  in  1: consumer takes the entry on the edge where out_valid && out_ready.
- ALU_output  out  WIDTH: result.
- out_wb  out  1: result is to be written back. It is 0 for TST/TEQ/CMP/CMN and for illegal ops.
- out_illegal  out  1: CTRL_cmd was reserved.
- NZCV  out  4: flag register. N is bit 3.

## Operation
- Opcodes:
  - 00000 AND, 00001 EOR, 00010 SUB, 00011 RSB, 00100 ADD, 00101 ADC, 00110 SBC, 00111 RSC.
  - 01000 TST, 01001 TEQ, 01010 CMP, 01011 CMN, 01100 ORR, 01101 MOV, 01110 BIC, 01111 MVN.
  - 10000 MUL (low WIDTH bits of src1*src2, unsigned).
  - 10001–11111: reserved.
- Arithmetic is computed in WIDTH+1 bits.
  - Subtraction is a + ~b + cin.
  - C = carry-out, so for subtract C = NOT borrow.
  - V = signed overflow of the WIDTH-bit result.
  - ADC/SBC/RSC use the current NZCV[1] as cin.
- Logical ops:
  - N and Z come from the result.
  - C = src2shift_carry if was_shifted, else unchanged.
  - V is unchanged.
- MUL: N and Z are updated; C and V are unchanged.
- Reserved ops:
  - ALU_output = 0, out_wb = 0, out_illegal = 1.
  - Flags are unchanged regardless of set_flags.
- Flags commit on the same edge the result loads into the output entry, and only when set_flags is set. TST/TEQ/CMP/CMN commit flags regardless of set_flags.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- FSM states: IDLE, MUL, FLUSH-free.
  - IDLE → MUL when a MUL is accepted.
  - MUL → IDLE after MUL_CYCLES iterations, loading the output entry.
  - Non-MUL ops are computed combinationally at acceptance and registered on the accept edge.
- Reset values:
  - out_valid = 0, ALU_output = 0, out_wb = 0, out_illegal = 0.
  - NZCV = 0000, state = IDLE.
  - in_ready rises one cycle after RESET_n deasserts.
- Boundary cases:
  - flush: clears out_valid and returns to IDLE on the next edge. NZCV is untouched. A request presented in the flush cycle is not accepted.
  - Reset mid-MUL: state is abandoned and no result is produced.
  - Output entry full and out_ready = 0: the entry holds stable and in_ready = 0.
  - Simultaneous pop and new accept: allowed, giving full throughput.

## Timing
- Non-MUL latency is 1: accepted at edge t, so out_valid is high after t and NZCV is updated after t.
- An op accepted at t+1 sees the NZCV committed at t, so there is no flag hazard.
- MUL latency is MUL_CYCLES + 1 edges from accept to out_valid. in_ready = 0 throughout.
- Sustained throughput is one non-MUL op per cycle while out_ready = 1.

## Structure
- Package alu_pkg holds:
  - the op_e enum with the 5-bit encodings above;
  - the flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;
  - the function is_test_op().
- Sub-module alu_mul_seq is a radix-2 shift-add multiplier with a start/done interface, parameter WIDTH, and a synchronous abort driven by flush.

## Test plan
- WIDTH = 32, NZCV = 0000, src1 = 5, src2 = 0xFFFFFFFA:
  - ADD → 0xFFFFFFFF, NZCV = 1000.
  - SUB → 0x0000000B, NZCV = 0000.
  - CMP → out_wb = 0, NZCV = 0000.
- ADDS 0xFFFFFFFF + 1 then ADC 0 + 0 back-to-back:
  - first op → 0, NZCV = 0110;
  - second op → 1;
  - one op per cycle throughout.
- MOV with was_shifted = 1, src2shift_carry = 1, set_flags = 1, src2 = 0x80000000 → NZCV = 1010, V unchanged.
- MUL 7 × 6:
  - in_ready is low for 32 cycles;
  - out_valid rises 33 edges after accept with ALU_output = 42;
  - C and V are preserved.
- out_ready held low for 5 cycles after an ADD: ALU_output is stable and in_ready = 0. The entry pops and a new op is accepted on the same edge.
- Reset and error cases:
  - flush at MUL iteration 10 → out_valid never rises and in_ready returns the next cycle.
  - RESET_n low mid-MUL → all outputs go to their reset values immediately.
  - CTRL_cmd = 10101 → out_illegal = 1, flags unchanged.
